mcdf: RTL and testbench
=======================

Name: mcdf

Overview:
- Multi-channel data formatter.
- Three 32-bit valid/ready slave channels each feed a per-channel FIFO.
- A priority arbiter picks a channel holding a full packet; the formatter streams it out as a framed packet after a req/grant handshake.
- A small register file, accessed through a cmd bus, configures each channel and reports FIFO free space.

Parameters:
- FIFO_DEPTH, 32, words per channel FIFO (power of two, ≥32).
- DW, 32, data width of channels and fmt_data.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-high reset (reset when rst_n=1 at clk edge).
- ch0_data / ch1_data / ch2_data  in  32  channel write data.
- ch0_valid / ch1_valid / ch2_valid  in  1  channel data valid.
- ch0_ready / ch1_ready / ch2_ready  out  1  channel can accept.
- fmt_grant  in  1  downstream grant.
- fmt_chid  out  2  channel id of requested/sent packet.
- fmt_length  out  6  packet length in words.
- fmt_req  out  1  packet request.
- fmt_data  out  32  packet data.
- fmt_start  out  1  first word marker.
- fmt_end  out  1  last word marker.
- cmd  in  2  00 IDLE, 01 RD, 10 WR, 11 ignored.
- cmd_addr  in  6  byte register address.
- cmd_data_i  in  32  write data.
- cmd_data_o  out  32  read data.

Behaviour:
- Registers:
  - 0x00/0x04/0x08 = CTRL0..2 (RW): bit0 en, bits[2:1] prio (0 = highest), bits[5:3] len_code; bits[31:6] read 0.
  - Reset value of each CTRL is 0x00000007 (en=1, prio=3, len_code=0).
  - 0x10/0x14/0x18 = STAT0..2 (RO): bits[7:0] FIFO free slots; other bits 0.
  - WR: updates CTRL at the clk edge; writes to STAT or unmapped addresses are ignored.
  - RD: cmd_data_o loads the addressed value at the clk edge (1-cycle latency); unmapped addresses read 0. cmd_data_o holds its value when cmd≠RD.
- Length decode: len_code 0→4, 1→8, 2→16, 3→32; codes 4–7 decode to 32.
- Slave channel:
  - chN_ready = enN && FIFO not full.
  - A word is pushed when chN_valid && chN_ready.
  - With en=0, ready=0 and the FIFO contents are retained.
- Arbiter:
  - Eligible channel: en=1, FIFO count ≥ decoded length, formatter IDLE.
  - Winner is the lowest prio value; ties go to the lowest channel id.
  - Winner is latched into fmt_chid and fmt_length.
- Formatter FSM:
  - IDLE → REQ when a winner exists.
  - REQ: fmt_req=1; leave on fmt_grant=1, SEND starting the next cycle.
  - SEND: pop one word per cycle onto fmt_data; fmt_start=1 on the first word, fmt_end=1 on the last; outputs registered.
  - END: one idle cycle with fmt_req=0, then back to IDLE.
  - fmt_grant is ignored outside REQ.
  - A push and a pop on the same FIFO in the same cycle are both honoured.
- Reset values:
  - All ready, req, start and end outputs 0.
  - fmt_data, fmt_chid, fmt_length and cmd_data_o are 0.
  - FIFOs empty (STAT = FIFO_DEPTH); FSM returns to IDLE.
  - Reset mid-packet aborts the packet immediately.
- Disabling a channel mid-packet does not abort a packet already granted.

Optional Feature:
- Macro: MCDF_STATUS_REGS_EN.
- Defined: STAT0..2 readable as specified.
- Undefined: STAT addresses read 0 and free-slot logic is not built.

Decomposition:
- Shared package mcdf_pkg holds:
  - cmd encodings (IDLE/RD/WR);
  - register address constants;
  - CTRL field positions;
  - the len_code→length decode function;
  - the FSM state typedef.
- One sub-module, mcdf_fifo (synchronous FIFO with count output), instantiated three times.

Test Plan:
- Reset then RD 0x00, 0x04, 0x08 → 0x00000007 each; RD 0x10 → 32 (feature on).
- WR 0x00=0x13, 0x04=0x01, 0x08=0x09, then RD back → 0x13, 0x01, 0x09; a WR to 0x10 leaves it unchanged.
- All channels valid with random data and fmt_grant held low → ch1 (len 4) reaches its threshold first; fmt_req=1 with fmt_chid=1, fmt_length=4 held until grant.
- Pulse fmt_grant for 2 cycles → 4 words out matching ch1's input order, start on word 1, end on word 4, then req drops for at least one cycle.
- ch0 prio 1/len 16 and ch2 prio 0/len 8, both FIFOs over threshold → ch2 wins first; on tie of prio, ch0 beats ch2.
- Fill ch2 to 32 words with grant low → ch2_ready=0, STAT2=0; after one packet drains, ready=1 and STAT2 = 8.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared definitions for the mcdf formatter: cmd encodings, register map,
// CTRL field layout, length decode and formatter state type.
package mcdf_pkg;

   localparam int unsigned NUM_CH = 3;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_RD   = 2'b01,
      CMD_WR   = 2'b10
   } cmd_t;

   localparam logic [5:0] ADDR_CTRL0 = 6'h00;
   localparam logic [5:0] ADDR_CTRL1 = 6'h04;
   localparam logic [5:0] ADDR_CTRL2 = 6'h08;
   localparam logic [5:0] ADDR_STAT0 = 6'h10;
   localparam logic [5:0] ADDR_STAT1 = 6'h14;
   localparam logic [5:0] ADDR_STAT2 = 6'h18;

   localparam int unsigned       CTRL_EN_BIT   = 0;
   localparam int unsigned       CTRL_PRIO_LSB = 1;
   localparam int unsigned       CTRL_LEN_LSB  = 3;
   localparam int unsigned       CTRL_W        = 6;
   localparam logic [CTRL_W-1:0] CTRL_RST      = 6'h07;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SEND,
      ST_END
   } fmt_state_t;

   function automatic logic [5:0] len_decode(input logic [2:0] code);
      case (code)
         3'd0:    return 6'd4;
         3'd1:    return 6'd8;
         3'd2:    return 6'd16;
         default: return 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/mcdf_if.sv
// Bundle of the mcdf channel, formatter and cmd-bus signals; slave is the
// formatter's view, master the driver's view.
interface mcdf_if #(
   parameter int unsigned DW = 32
);
   logic [DW-1:0] ch0_data, ch1_data, ch2_data;
   logic          ch0_valid, ch1_valid, ch2_valid;
   logic          ch0_ready, ch1_ready, ch2_ready;

   logic          fmt_grant;
   logic [1:0]    fmt_chid;
   logic [5:0]    fmt_length;
   logic          fmt_req;
   logic [DW-1:0] fmt_data;
   logic          fmt_start;
   logic          fmt_end;

   logic [1:0]    cmd;
   logic [5:0]    cmd_addr;
   logic [31:0]   cmd_data_i;
   logic [31:0]   cmd_data_o;

   modport slave (
      input  ch0_data, ch1_data, ch2_data, ch0_valid, ch1_valid, ch2_valid,
      input  fmt_grant, cmd, cmd_addr, cmd_data_i,
      output ch0_ready, ch1_ready, ch2_ready,
      output fmt_chid, fmt_length, fmt_req, fmt_data, fmt_start, fmt_end,
      output cmd_data_o
   );

   modport master (
      output ch0_data, ch1_data, ch2_data, ch0_valid, ch1_valid, ch2_valid,
      output fmt_grant, cmd, cmd_addr, cmd_data_i,
      input  ch0_ready, ch1_ready, ch2_ready,
      input  fmt_chid, fmt_length, fmt_req, fmt_data, fmt_start, fmt_end,
      input  cmd_data_o
   );
endinterface

// File: rtl/mcdf_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; simultaneous push and pop
// are both honoured.
module mcdf_fifo #(
   parameter  int unsigned DEPTH = 32,
   parameter  int unsigned DW    = 32,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_rdata,
   output logic [AW:0]   o_count,
   output logic          o_full
);
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic          w_push, w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && (r_count != '0);
   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/mcdf.sv
// Multi-channel data formatter: three channel FIFOs, priority arbiter, framed
// packet output and cmd-bus register file. STAT regs built only with MCDF_STATUS_REGS_EN.
module mcdf
   import mcdf_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned DW         = 32
) (
   input logic   clk,
   input logic   rst_n,
   mcdf_if.slave bus
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [DW-1:0]     w_wdata [NUM_CH];
   logic [DW-1:0]     w_rdata [NUM_CH];
   logic [CW-1:0]     w_count [NUM_CH];
   logic [NUM_CH-1:0] w_valid, w_ready, w_full, w_pop;
   logic [CTRL_W-1:0] r_ctrl  [NUM_CH];

   assign w_wdata[0] = bus.ch0_data;
   assign w_wdata[1] = bus.ch1_data;
   assign w_wdata[2] = bus.ch2_data;
   assign w_valid    = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};

   // ready is held low while reset is asserted, even though en resets to 1
   always_comb begin
      w_ready = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         w_ready[i] = r_ctrl[i][CTRL_EN_BIT] && !w_full[i] && !rst_n;
   end

   assign bus.ch0_ready = w_ready[0];
   assign bus.ch1_ready = w_ready[1];
   assign bus.ch2_ready = w_ready[2];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      mcdf_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_valid[g] && w_ready[g]),
         .i_wdata (w_wdata[g]),
         .i_pop   (w_pop[g]),
         .o_rdata (w_rdata[g]),
         .o_count (w_count[g]),
         .o_full  (w_full[g])
      );
   end

   logic       w_win_vld;
   logic [1:0] w_win_id, w_win_prio;
   logic [5:0] w_win_len;

   // strict less-than keeps the lowest channel id on a priority tie
   always_comb begin
      w_win_vld  = 1'b0;
      w_win_id   = '0;
      w_win_prio = '1;
      w_win_len  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (r_ctrl[i][CTRL_EN_BIT] &&
             (w_count[i] >= CW'(len_decode(r_ctrl[i][CTRL_LEN_LSB +: 3]))) &&
             (!w_win_vld || (r_ctrl[i][CTRL_PRIO_LSB +: 2] < w_win_prio))) begin
            w_win_vld  = 1'b1;
            w_win_id   = 2'(i);
            w_win_prio = r_ctrl[i][CTRL_PRIO_LSB +: 2];
            w_win_len  = len_decode(r_ctrl[i][CTRL_LEN_LSB +: 3]);
         end
      end
   end

   fmt_state_t    r_state, w_state_nxt;
   logic [1:0]    r_chid;
   logic [5:0]    r_len, r_cnt;
   logic [DW-1:0] r_fmt_data, w_sel_data;
   logic          r_start, r_end, w_req, w_last;

   assign w_last = (r_cnt == r_len - 6'd1);

   always_ff @(posedge clk) begin
      if (rst_n) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_pop       = '0;
      case (r_state)
         ST_IDLE: if (w_win_vld) w_state_nxt = ST_REQ;
         ST_REQ: begin
            w_req = 1'b1;
            if (bus.fmt_grant) w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            for (int unsigned i = 0; i < NUM_CH; i++) w_pop[i] = (r_chid == 2'(i));
            if (w_last) w_state_nxt = ST_END;
         end
         ST_END:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_sel_data = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (r_chid == 2'(i)) w_sel_data = w_rdata[i];
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_chid     <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_fmt_data <= '0;
         r_start    <= 1'b0;
         r_end      <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_end   <= 1'b0;
         if ((r_state == ST_IDLE) && w_win_vld) begin
            r_chid <= w_win_id;
            r_len  <= w_win_len;
            r_cnt  <= '0;
         end
         if (r_state == ST_SEND) begin
            r_fmt_data <= w_sel_data;
            r_start    <= (r_cnt == '0);
            r_end      <= w_last;
            r_cnt      <= r_cnt + 6'd1;
         end
      end
   end

   assign bus.fmt_req    = w_req;
   assign bus.fmt_chid   = r_chid;
   assign bus.fmt_length = r_len;
   assign bus.fmt_data   = r_fmt_data;
   assign bus.fmt_start  = r_start;
   assign bus.fmt_end    = r_end;

   cmd_t        w_cmd;
   logic [31:0] w_rd_val, r_cmd_rdata;
   logic        w_unused_cmd_hi;

   assign w_cmd           = cmd_t'(bus.cmd);
   assign w_unused_cmd_hi = ^bus.cmd_data_i[31:CTRL_W];

`ifdef MCDF_STATUS_REGS_EN
   logic [7:0] w_free [NUM_CH];
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++)
         w_free[i] = 8'(FIFO_DEPTH - 32'(w_count[i]));
   end
`endif

   always_comb begin
      w_rd_val = '0;
      case (bus.cmd_addr)
         ADDR_CTRL0: w_rd_val = {{(32-CTRL_W){1'b0}}, r_ctrl[0]};
         ADDR_CTRL1: w_rd_val = {{(32-CTRL_W){1'b0}}, r_ctrl[1]};
         ADDR_CTRL2: w_rd_val = {{(32-CTRL_W){1'b0}}, r_ctrl[2]};
`ifdef MCDF_STATUS_REGS_EN
         ADDR_STAT0: w_rd_val = {24'd0, w_free[0]};
         ADDR_STAT1: w_rd_val = {24'd0, w_free[1]};
         ADDR_STAT2: w_rd_val = {24'd0, w_free[2]};
`endif
         default:    w_rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) r_ctrl[i] <= CTRL_RST;
         r_cmd_rdata <= '0;
      end else begin
         if (w_cmd == CMD_WR) begin
            case (bus.cmd_addr)
               ADDR_CTRL0: r_ctrl[0] <= bus.cmd_data_i[CTRL_W-1:0];
               ADDR_CTRL1: r_ctrl[1] <= bus.cmd_data_i[CTRL_W-1:0];
               ADDR_CTRL2: r_ctrl[2] <= bus.cmd_data_i[CTRL_W-1:0];
               default: ;
            endcase
         end
         if (w_cmd == CMD_RD) r_cmd_rdata <= w_rd_val;
      end
   end

   assign bus.cmd_data_o = r_cmd_rdata;

endmodule

// File: tb/tb_mcdf.sv
// Scoreboard bench for mcdf: channel pushes are queued per channel and popped
// against each framed output word; register and arbitration results checked inline.
module tb_mcdf;

`ifdef MCDF_STATUS_REGS_EN
   localparam bit STAT_ON = 1'b1;
`else
   localparam bit STAT_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;

   mcdf_if #(.DW(32)) bus ();

   mcdf #(.FIFO_DEPTH(32), .DW(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] stat_exp(input int unsigned free);
      return STAT_ON ? 32'(free) : 32'd0;
   endfunction

   logic [31:0] tb_data [3];
   logic [2:0]  tb_valid;
   logic [2:0]  drive_en;

   assign bus.ch0_data  = tb_data[0];
   assign bus.ch1_data  = tb_data[1];
   assign bus.ch2_data  = tb_data[2];
   assign bus.ch0_valid = tb_valid[0];
   assign bus.ch1_valid = tb_valid[1];
   assign bus.ch2_valid = tb_valid[2];

   initial begin
      tb_valid = '0;
      for (int i = 0; i < 3; i++) tb_data[i] = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            tb_valid[i] = drive_en[i];
            tb_data[i]  = $urandom;
         end
      end
   end

   logic [31:0] q0[$], q1[$], q2[$];
   logic [1:0]  exp_ch;
   logic [5:0]  exp_len;
   int unsigned n_pkts = 0;
   int unsigned widx   = 0;
   bit          in_pkt = 0;
   bit          gap_chk = 0;

   function automatic logic [31:0] sb_pop(input logic [1:0] ch);
      logic [31:0] v;
      v = 32'hDEAD_BEEF;
      case (ch)
         2'd0: if (q0.size() > 0) v = q0.pop_front();
         2'd1: if (q1.size() > 0) v = q1.pop_front();
         default: if (q2.size() > 0) v = q2.pop_front();
      endcase
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n == 1'b0) begin
         if (tb_valid[0] && bus.ch0_ready) q0.push_back(tb_data[0]);
         if (tb_valid[1] && bus.ch1_ready) q1.push_back(tb_data[1]);
         if (tb_valid[2] && bus.ch2_ready) q2.push_back(tb_data[2]);

         if (gap_chk) begin
            check_eq("req_gap", 32'(bus.fmt_req), 32'd0);
            gap_chk = 0;
         end

         if (!in_pkt) begin
            if (bus.fmt_end) check_eq("end_stray", 32'(bus.fmt_end), 32'd0);
            if (bus.fmt_start) begin
               in_pkt = 1;
               widx   = 0;
               check_eq("pkt_chid", 32'(bus.fmt_chid), 32'(exp_ch));
            end
         end else begin
            check_eq("start_mid", 32'(bus.fmt_start), 32'd0);
         end

         if (in_pkt) begin
            check_eq("fmt_data", bus.fmt_data, sb_pop(exp_ch));
            widx++;
            if (bus.fmt_end) begin
               check_eq("pkt_len", widx, 32'(exp_len));
               check_eq("req_at_end", 32'(bus.fmt_req), 32'd0);
               in_pkt  = 0;
               gap_chk = 1;
               n_pkts++;
            end else if (widx >= 32'(exp_len)) begin
               check_eq("pkt_overrun", widx + 1, 32'(exp_len));
               in_pkt = 0;
               n_pkts++;
            end
         end
      end
   end

   task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.cmd = 2'b10; bus.cmd_addr = a; bus.cmd_data_i = d;
      @(posedge clk); #1;
      bus.cmd = 2'b00;
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
      @(posedge clk); #1;
      bus.cmd = 2'b01; bus.cmd_addr = a;
      @(posedge clk); #1;
      bus.cmd = 2'b00;
      check_eq(tag, bus.cmd_data_o, exp);
   endtask

   task automatic wait_req(input logic [1:0] ch, input logic [5:0] len);
      int unsigned k = 0;
      @(negedge clk);
      while (bus.fmt_req !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_eq("req_up", 32'(bus.fmt_req), 32'd1);
      check_eq("req_chid", 32'(bus.fmt_chid), 32'(ch));
      check_eq("req_len", 32'(bus.fmt_length), 32'(len));
      exp_ch  = ch;
      exp_len = len;
   endtask

   task automatic grant_pulse();
      @(posedge clk); #1;
      bus.fmt_grant = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.fmt_grant = 1'b0;
   endtask

   task automatic wait_pkt(input int unsigned n);
      int unsigned k = 0;
      while (n_pkts < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_eq("pkt_done", n_pkts, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n          = 1'b1;
      drive_en       = '0;
      bus.fmt_grant  = 1'b0;
      bus.cmd        = 2'b00;
      bus.cmd_addr   = '0;
      bus.cmd_data_i = '0;
      exp_ch         = '0;
      exp_len        = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", 32'({bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}), 32'd0);
      check_eq("rst_req", 32'(bus.fmt_req), 32'd0);
      check_eq("rst_start_end", 32'({bus.fmt_start, bus.fmt_end}), 32'd0);
      check_eq("rst_data", bus.fmt_data, 32'd0);
      check_eq("rst_chid_len", 32'({bus.fmt_chid, bus.fmt_length}), 32'd0);
      check_eq("rst_cmd_o", bus.cmd_data_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", 32'({bus.ch2_ready, bus.ch1_ready, bus.ch0_ready}), 32'h7);

      rd_chk("ctrl1_rst", 6'h04, 32'h7);
      rd_chk("ctrl2_rst", 6'h08, 32'h7);
      rd_chk("stat0_rst", 6'h10, stat_exp(32));
      rd_chk("unmapped", 6'h0C, 32'h0);
      rd_chk("ctrl0_rst", 6'h00, 32'h7);
      reg_wr(6'h00, 32'h13);
      check_eq("rd_hold", bus.cmd_data_o, 32'h7);
      reg_wr(6'h04, 32'hABCD_EF01);
      reg_wr(6'h08, 32'h09);
      reg_wr(6'h10, 32'hFF);
      rd_chk("ctrl0_wr", 6'h00, 32'h13);
      rd_chk("ctrl1_wr", 6'h04, 32'h01);
      rd_chk("ctrl2_wr", 6'h08, 32'h09);
      rd_chk("stat0_ro", 6'h10, stat_exp(32));

      // ch1 (prio 0, len 4) reaches its threshold first
      drive_en = 3'b111;
      repeat (20) @(posedge clk);
      drive_en = 3'b000;
      wait_req(2'd1, 6'd4);
      repeat (5) @(negedge clk);
      check_eq("req_held", 32'({bus.fmt_req, bus.fmt_chid}), 32'({1'b1, 2'd1}));
      grant_pulse();
      reg_wr(6'h04, 32'h00);
      wait_pkt(1);
      @(negedge clk);
      check_eq("ch1_dis_ready", 32'(bus.ch1_ready), 32'd0);

      // ch2 prio 0 beats ch0 prio 1; ch2 keeps streaming while it drains
      wait_req(2'd2, 6'd8);
      drive_en = 3'b100;
      grant_pulse();
      reg_wr(6'h00, 32'h11);
      wait_pkt(2);

      // equal priority: ch0 wins over ch2
      wait_req(2'd0, 6'd16);
      repeat (40) @(posedge clk);
      @(negedge clk);
      check_eq("ch2_full_ready", 32'(bus.ch2_ready), 32'd0);
      rd_chk("stat2_full", 6'h18, 32'd0);
      drive_en = 3'b000;
      grant_pulse();
      wait_pkt(3);

      wait_req(2'd2, 6'd8);
      grant_pulse();
      wait_pkt(4);
      @(negedge clk);
      check_eq("ch2_drain_ready", 32'(bus.ch2_ready), 32'd1);
      rd_chk("stat2_drain", 6'h18, stat_exp(8));
      rd_chk("stat1_model", 6'h14, stat_exp(32 - q1.size()));
      rd_chk("stat0_model", 6'h10, stat_exp(32 - q0.size()));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
